// File: rtl/parking_gate_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
//   Shared types for the parking gate scheduler: the scheduler FSM state
//   encoding, the upper bound on gates per lane, and the gate index type used
//   by the round-robin arbiters and the scheduler's captured-gate register.
//   No ports.
// -----------------------------------------------------------------------------
package parking_pkg;

  localparam int MAX_GATES  = 8;
  localparam int GATE_IDX_W = $clog2(MAX_GATES);

  typedef logic [GATE_IDX_W-1:0] gate_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PULSE_E,
    PULSE_X,
    SETTLE,
    ACK,
    REJ
  } sched_state_t;

endpackage

// File: rtl/parking_gate_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for one request lane. The search starts at the stored
//   pointer and wraps; the first requesting gate wins. The pointer moves to
//   winner+1 (mod N) only when the caller captures the winner (advance).
// Ports
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset (pointer -> 0)
//   req      in   N   request vector
//   advance  in   1   winner captured this cycle; move pointer past it
//   grant    out  N   one-hot winner (all zero when no request)
//   idx      out  -   binary index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter
  import parking_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output gate_idx_t    idx
);

  gate_idx_t r_ptr;

  // NOTE: every signal written here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int   j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = gate_idx_t'(j);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (idx == gate_idx_t'(N-1)) ? '0 : idx + gate_idx_t'(1);
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// -----------------------------------------------------------------------------
// parking_gate_scheduler
//   Serialises entry/exit requests from N_GATES entry gates and N_GATES exit
//   gates onto the single car_entered/car_exited event interface of
//   ParkingSystem. Entries are admitted only when the vacancy flag of the car's
//   class is set, otherwise rejected. Exits take priority over entries, but at
//   most EXIT_BURST exits are served back-to-back while an entry waits.
//
//   Optional feature macro: PARK_REJ_CNT_EN adds saturating 16-bit reject
//   counters per class (rej_cnt_uni, rej_cnt_gen).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ent_req/ent_uni   in  N     entry request (level) and car class
//   ent_ack/ent_rej   out N     one-cycle entry issued / refused pulse
//   ext_req/ext_uni   in  N     exit request (level) and car class
//   ext_ack           out N     one-cycle exit issued pulse
//   uni_is_vacated_space in 1   university space available
//   is_vacated_space  in  1     general space available
//   car_entered, is_uni_car_entered  out  entry event strobe and class
//   car_exited,  is_uni_car_exited   out  exit event strobe and class
//   busy              out 1     scheduler not idle
//   rej_cnt_uni/gen   out 16    (PARK_REJ_CNT_EN only) rejects per class
// -----------------------------------------------------------------------------
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int N_GATES    = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 2,
  parameter int EXIT_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_GATES-1:0] ent_req,
  input  logic [N_GATES-1:0] ent_uni,
  output logic [N_GATES-1:0] ent_ack,
  output logic [N_GATES-1:0] ent_rej,
  input  logic [N_GATES-1:0] ext_req,
  input  logic [N_GATES-1:0] ext_uni,
  output logic [N_GATES-1:0] ext_ack,
  input  logic               uni_is_vacated_space,
  input  logic               is_vacated_space,
  output logic               car_entered,
  output logic               is_uni_car_entered,
  output logic               car_exited,
  output logic               is_uni_car_exited,
  output logic               busy
`ifdef PARK_REJ_CNT_EN
  ,
  output logic [15:0]        rej_cnt_uni,
  output logic [15:0]        rej_cnt_gen
`endif
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BURST_W = $clog2(EXIT_BURST + 1);

  sched_state_t        r_state;
  gate_idx_t           r_gate;
  logic                r_uni;
  logic                r_is_exit;
  logic [CNT_W-1:0]    r_cnt;
  logic [BURST_W-1:0]  r_burst;

  logic [N_GATES-1:0]  w_ent_grant;
  logic [N_GATES-1:0]  w_ext_grant;
  gate_idx_t           w_ent_idx;
  gate_idx_t           w_ext_idx;
  logic                w_ent_any;
  logic                w_ext_any;
  logic                w_sel_exit;
  logic                w_sel_entry;
  logic                w_ent_uni_sel;
  logic                w_ext_uni_sel;
  logic                w_vacant;
  logic [N_GATES-1:0]  w_gate_oh;

  assign w_ent_any = |ent_req;
  assign w_ext_any = |ext_req;

  // Exits win unless an entry is waiting and the exit burst is used up.
  assign w_sel_exit  = (r_state == IDLE) && w_ext_any &&
                       (!w_ent_any || (r_burst < BURST_W'(EXIT_BURST)));
  assign w_sel_entry = (r_state == IDLE) && !w_sel_exit && w_ent_any;

  assign w_ent_uni_sel = |(ent_uni & w_ent_grant);
  assign w_ext_uni_sel = |(ext_uni & w_ext_grant);

  // Vacancy is looked at only in CHECK, for the class of the captured car.
  assign w_vacant  = r_uni ? uni_is_vacated_space : is_vacated_space;
  assign w_gate_oh = N_GATES'(1) << r_gate;

  assign busy = (r_state != IDLE);

  rr_arbiter #(.N(N_GATES)) u_ent_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ent_req),
    .advance (w_sel_entry),
    .grant   (w_ent_grant),
    .idx     (w_ent_idx)
  );

  rr_arbiter #(.N(N_GATES)) u_ext_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ext_req),
    .advance (w_sel_exit),
    .grant   (w_ext_grant),
    .idx     (w_ext_idx)
  );

  // Consecutive exits served while an entry waits. Cleared as soon as no entry
  // is pending or an entry is captured, so the cap only throttles exits that
  // are actually delaying an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (!w_ent_any || w_sel_entry) begin
      r_burst <= '0;
    end else if (w_sel_exit) begin
      r_burst <= r_burst + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_gate             <= '0;
      r_uni              <= 1'b0;
      r_is_exit          <= 1'b0;
      r_cnt              <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      ent_ack            <= '0;
      ent_rej            <= '0;
      ext_ack            <= '0;
`ifdef PARK_REJ_CNT_EN
      rej_cnt_uni        <= '0;
      rej_cnt_gen        <= '0;
`endif
    end else begin
      // Ack/reject outputs are single-cycle; they are set only on the
      // transition into ACK/REJ.
      ent_ack <= '0;
      ent_rej <= '0;
      ext_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_sel_exit) begin
            r_gate            <= w_ext_idx;
            r_uni             <= w_ext_uni_sel;
            r_is_exit         <= 1'b1;
            r_cnt             <= '0;
            car_exited        <= 1'b1;
            is_uni_car_exited <= w_ext_uni_sel;
            r_state           <= PULSE_X;
          end else if (w_sel_entry) begin
            r_gate    <= w_ent_idx;
            r_uni     <= w_ent_uni_sel;
            r_is_exit <= 1'b0;
            r_state   <= CHECK;
          end
        end
        CHECK: begin
          if (w_vacant) begin
            r_cnt              <= '0;
            car_entered        <= 1'b1;
            is_uni_car_entered <= r_uni;
            r_state            <= PULSE_E;
          end else begin
            ent_rej <= w_gate_oh;
            r_state <= REJ;
`ifdef PARK_REJ_CNT_EN
            if (r_uni) begin
              if (rej_cnt_uni != 16'hFFFF) rej_cnt_uni <= rej_cnt_uni + 16'd1;
            end else begin
              if (rej_cnt_gen != 16'hFFFF) rej_cnt_gen <= rej_cnt_gen + 16'd1;
            end
`endif
          end
        end
        PULSE_E, PULSE_X: begin
          if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
            car_entered <= 1'b0;
            car_exited  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
            // Class flags stay valid through SETTLE and drop with the ack.
            is_uni_car_entered <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            if (r_is_exit) ext_ack <= w_gate_oh;
            else           ent_ack <= w_gate_oh;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACK, REJ: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

endmodule
